// File: rtl/pio_input_conditioner.sv
// Board-side input conditioner for the PIO input word: synchronizes and debounces
// slide switches and push-buttons, and latches sticky press events until the host acknowledges them.
module pio_input_conditioner #(
  parameter int SW_WIDTH        = 11,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  raw_sw,
  input  logic [BTN_WIDTH-1:0] raw_btn,
  input  logic [7:0]           ack_port,
  output logic [15:0]          inport_data,
  output logic [BTN_WIDTH-1:0] btn_level
);

  localparam int NB    = SW_WIDTH + BTN_WIDTH;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BTN_WIDTH-1:0] BTN_IDLE  = (BTN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NB-1:0]        SYNC_IDLE = {BTN_IDLE, {SW_WIDTH{1'b0}}};

  logic [NB-1:0]        sync_p0;
  logic [NB-1:0]        sync_p1;
  logic [NB-1:0]        lvl_p1;
  logic [NB-1:0]        stable_p2;
  logic [CNT_W-1:0]     cnt_p2 [NB];
  logic [BTN_WIDTH-1:0] press_p2;
  logic [BTN_WIDTH-1:0] btn_event;
  logic [BTN_WIDTH-1:0] clr_mask;
  logic                 overrun;
  logic                 ovr_set;
  logic                 ack_prev;
  logic                 clr;
  logic                 unused_ack;

  // Stage p0/p1: two-flop synchronizer, buttons flipped to pressed-high after the second flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= SYNC_IDLE;
      sync_p1 <= SYNC_IDLE;
    end else begin
      sync_p0 <= {raw_btn, raw_sw};
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    lvl_p1 = sync_p1;
    if (BTN_ACTIVE_LOW != 0) begin
      lvl_p1[NB-1:SW_WIDTH] = ~sync_p1[NB-1:SW_WIDTH];
    end
  end

  // Stage p2: per-bit debounce; any sample matching the accepted level restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_p2 <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (lvl_p1[i] != stable_p2[i]) begin
          if (cnt_p2[i] == CNT_MAX) begin
            stable_p2[i] <= lvl_p1[i];
            cnt_p2[i]    <= '0;
          end else begin
            cnt_p2[i] <= cnt_p2[i] + 1'b1;
          end
        end else begin
          cnt_p2[i] <= '0;
        end
      end
    end
  end

  // A press is the edge where a button's accepted level flips 0->1
  always_comb begin
    for (int i = 0; i < BTN_WIDTH; i++) begin
      press_p2[i] = lvl_p1[SW_WIDTH+i] && !stable_p2[SW_WIDTH+i] &&
                    (cnt_p2[SW_WIDTH+i] == CNT_MAX);
    end
  end

  assign clr        = ack_port[7] & ~ack_prev;
  assign clr_mask   = {BTN_WIDTH{clr}} & ack_port[BTN_WIDTH-1:0];
  assign ovr_set    = |(press_p2 & btn_event & ~clr_mask);
  assign unused_ack = ^ack_port;

  // Sticky event flags: a set always wins over a coincident clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_prev  <= 1'b1;
      btn_event <= '0;
      overrun   <= 1'b0;
    end else begin
      ack_prev  <= ack_port[7];
      btn_event <= press_p2 | (btn_event & ~clr_mask);
      overrun   <= ovr_set | (overrun & ~(clr & ack_port[6]));
    end
  end

  assign inport_data = {overrun, btn_event, stable_p2[SW_WIDTH-1:0]};
  assign btn_level   = stable_p2[NB-1:SW_WIDTH];

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Directed, table-driven bench for pio_input_conditioner with a short debounce window.
module tb_pio_input_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] raw_sw;
  logic [3:0]  raw_btn;
  logic [7:0]  ack_port;
  logic [15:0] inport_data;
  logic [3:0]  btn_level;

  pio_input_conditioner #(
    .SW_WIDTH(11),
    .BTN_WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_sw(raw_sw),
    .raw_btn(raw_btn),
    .ack_port(ack_port),
    .inport_data(inport_data),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] sw;
    logic [3:0]  btn;
    logic [7:0]  ack;
    logic [15:0] exp_data;
    logic [3:0]  exp_lvl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   split;

  task automatic add_n(input int n, input logic [10:0] sw, input logic [3:0] btn,
                       input logic [7:0] ack, input logic [15:0] d, input logic [3:0] l);
    vec_t v;
    v.sw = sw; v.btn = btn; v.ack = ack; v.exp_data = d; v.exp_lvl = l;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] d, input logic [3:0] l);
    checks++;
    if (inport_data !== d || btn_level !== l) begin
      errors++;
      $display("FAIL %s: inport_data=%h btn_level=%h, expected inport_data=%h btn_level=%h",
               name, inport_data, btn_level, d, l);
    end
  endtask

  task automatic run(input int from, input int to);
    for (int i = from; i < to; i++) begin
      raw_sw   = vecs[i].sw;
      raw_btn  = vecs[i].btn;
      ack_port = vecs[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_lvl);
    end
  endtask

  initial begin
    reset    = 1'b1;
    raw_sw   = 11'h7FF;
    raw_btn  = 4'hF;
    ack_port = 8'h00;

    // reset propagation: switches accepted after edge 6
    add_n(5, 11'h7FF, 4'hF, 8'h00, 16'h0000, 4'h0);
    add_n(2, 11'h7FF, 4'hF, 8'h00, 16'h07FF, 4'h0);
    split = vecs.size();
    // 3-cycle glitch rejected
    add_n(3, 11'h001, 4'hF, 8'h00, 16'h0000, 4'h0);
    add_n(5, 11'h000, 4'hF, 8'h00, 16'h0000, 4'h0);
    // 4-cycle pulse accepted, then released
    add_n(4, 11'h001, 4'hF, 8'h00, 16'h0000, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h0000, 4'h0);
    add_n(4, 11'h000, 4'hF, 8'h00, 16'h0001, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h0000, 4'h0);
    // btn2 press capture and release
    add_n(5, 11'h000, 4'hB, 8'h00, 16'h0000, 4'h0);
    add_n(5, 11'h000, 4'hB, 8'h00, 16'h2000, 4'h4);
    add_n(5, 11'h000, 4'hF, 8'h00, 16'h2000, 4'h4);
    add_n(2, 11'h000, 4'hF, 8'h00, 16'h2000, 4'h0);
    // clear handshake; holding bit 7 clears nothing further
    add_n(2, 11'h000, 4'hF, 8'h84, 16'h0000, 4'h0);
    add_n(5, 11'h000, 4'hB, 8'h84, 16'h0000, 4'h0);
    add_n(3, 11'h000, 4'hB, 8'h84, 16'h2000, 4'h4);
    add_n(5, 11'h000, 4'hF, 8'h84, 16'h2000, 4'h4);
    add_n(1, 11'h000, 4'hF, 8'h84, 16'h2000, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h2000, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'h84, 16'h0000, 4'h0);
    // overrun: btn0 pressed twice without a clear
    add_n(5, 11'h000, 4'hE, 8'h00, 16'h0000, 4'h0);
    add_n(1, 11'h000, 4'hE, 8'h00, 16'h0800, 4'h1);
    add_n(5, 11'h000, 4'hF, 8'h00, 16'h0800, 4'h1);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h0800, 4'h0);
    add_n(5, 11'h000, 4'hE, 8'h00, 16'h0800, 4'h0);
    add_n(1, 11'h000, 4'hE, 8'h00, 16'h8800, 4'h1);
    add_n(5, 11'h000, 4'hF, 8'h00, 16'h8800, 4'h1);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h8800, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'hC1, 16'h0000, 4'h0);
    // btn1: set event, then second press coincides with the clear edge
    add_n(5, 11'h000, 4'hD, 8'h00, 16'h0000, 4'h0);
    add_n(1, 11'h000, 4'hD, 8'h00, 16'h1000, 4'h2);
    add_n(5, 11'h000, 4'hF, 8'h00, 16'h1000, 4'h2);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h1000, 4'h0);
    add_n(5, 11'h000, 4'hD, 8'h00, 16'h1000, 4'h0);
    add_n(1, 11'h000, 4'hD, 8'h82, 16'h1000, 4'h2);
    add_n(5, 11'h000, 4'hF, 8'h82, 16'h1000, 4'h2);
    add_n(1, 11'h000, 4'hF, 8'h82, 16'h1000, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h1000, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'h82, 16'h0000, 4'h0);
    // btn3: ack bits 4/5 are ignored, bit 3 clears
    add_n(5, 11'h000, 4'h7, 8'h00, 16'h0000, 4'h0);
    add_n(1, 11'h000, 4'h7, 8'h00, 16'h4000, 4'h8);
    add_n(5, 11'h000, 4'hF, 8'h00, 16'h4000, 4'h8);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h4000, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'hB0, 16'h4000, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'h00, 16'h4000, 4'h0);
    add_n(1, 11'h000, 4'hF, 8'h88, 16'h0000, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 16'h0000, 4'h0);
    reset = 1'b0;
    run(0, split);

    // switches start counting down, then an asynchronous reset lands mid-count
    raw_sw = 11'h000;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("pre_reset", 16'h07FF, 4'h0);
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 16'h0000, 4'h0);
    @(posedge clk);
    #1;
    check("reset_held", 16'h0000, 4'h0);
    reset = 1'b0;

    run(split, vecs.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
